// File: rtl/imem_boot_loader_if.sv
// Load-port and instruction-memory write-port bundle for the boot loader.
// The master drives the byte stream in; the slave (loader) drives writes out.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: byte stream -> little-endian words -> imem writes.
// Holds the core in reset until a checksum-verified image is in place.
module imem_boot_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    imem_boot_loader_if.slave bus,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0]    DEPTH_B = 8'(DEPTH);
    localparam logic [ADDR_W:0] WL_ONE = 1;

    state_t            state;
    state_t            state_nxt;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   n_words;
    logic [1:0]        byte_idx;
    logic [7:0]        csum;

    logic accept;
    logic launch;
    logic hdr_bad;
    logic last_word;

    assign bus.byte_ready = byte_ready;
    assign bus.mem_we     = mem_we;
    assign bus.mem_waddr  = mem_waddr;
    assign bus.mem_wdata  = mem_wdata;

    // byte_ready is a registered flag, so accept never loops back to it
    assign accept    = bus.byte_valid && byte_ready;
    assign launch    = start && (state == IDLE || state == DONE
                                 || state == ERROR);
    assign hdr_bad   = (bus.byte_in == 8'd0) || (bus.byte_in > DEPTH_B);
    assign last_word = (words_loaded + WL_ONE) == n_words;

    // Next-state selection
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = HEADER;
            HEADER:  if (accept) state_nxt = hdr_bad ? ERROR : LOAD;
            LOAD:    if (accept && byte_idx == 2'd3) state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? CHECK : LOAD;
            CHECK:   if (accept)
                         state_nxt = (bus.byte_in == csum) ? DONE : ERROR;
            DONE:    if (launch) state_nxt = HEADER;
            ERROR:   if (launch) state_nxt = HEADER;
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered status flags and word-assembly datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_ready   <= 1'b0;
            mem_we       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            core_rst_n   <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            n_words      <= '0;
            byte_idx     <= '0;
            csum         <= '0;
        end else begin
            state      <= state_nxt;
            byte_ready <= state_nxt inside {HEADER, LOAD, CHECK};
            mem_we     <= state_nxt == WRITE;
            busy       <= state_nxt inside {HEADER, LOAD, WRITE, CHECK};
            done       <= state_nxt == DONE;
            error      <= state_nxt == ERROR;
            core_rst_n <= state_nxt == DONE;

            if (launch) begin
                words_loaded <= '0;
                byte_idx     <= '0;
                mem_waddr    <= '0;
                csum         <= '0;
                n_words      <= '0;
            end

            if (state == HEADER && accept && !hdr_bad)
                n_words <= bus.byte_in[ADDR_W:0];

            if (state == LOAD && accept) begin
                mem_wdata[8*byte_idx +: 8] <= bus.byte_in;
                csum                       <= csum ^ bus.byte_in;
                byte_idx                   <= byte_idx + 2'd1;
            end

            if (state == WRITE) begin
                mem_waddr    <= mem_waddr + 1'b1;
                words_loaded <= words_loaded + WL_ONE;
                byte_idx     <= '0;
            end
        end
    end

endmodule
